cache_miss_unit: RTL

- Per-cache miss handler between one L1 cache (I or D) and one connection slot of the cache/memory bus arbiter.
- Accepts one line miss at a time from the cache.
- If the victim line is dirty, issues a line writeback store to the arbiter first, then a line load.
- Captures the returned line and hands it back to the cache as a fill.
- One instance per arbiter connection; `CACHE_ID` selects the slot.

---
 rtl/cache_bus_pkg.sv | 26 ++
 rtl/cache_miss_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cache_bus_pkg.sv
// Shared types and helpers for the L1 miss units and the cache/memory bus arbiter.
// Line geometry defaults to 64-bit beats, 8 beats per line (512-bit lines).
package cache_bus_pkg;

    localparam int BUS_DATA_WIDTH   = 64;
    localparam int BUS_ADDR_WIDTH   = 64;
    localparam int BUS_CHUNKS_LOG   = 3;
    localparam int LINE_WIDTH       = BUS_DATA_WIDTH * (2 ** BUS_CHUNKS_LOG);
    localparam int LINE_OFFSET_BITS = $clog2(BUS_DATA_WIDTH / 8) + BUS_CHUNKS_LOG;

    typedef logic [LINE_WIDTH-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        LD_REQ  = 3'd3,
        LD_WAIT = 3'd4,
        FILL    = 3'd5
    } miss_state_e;

    function automatic logic [BUS_ADDR_WIDTH-1:0] line_align(input logic [BUS_ADDR_WIDTH-1:0] addr);
        return addr & ({BUS_ADDR_WIDTH{1'b1}} << LINE_OFFSET_BITS);
    endfunction

endpackage

// File: rtl/cache_miss_unit.sv
// One-miss-at-a-time L1 miss handler: optional dirty writeback, then line load, then fill.
// Command appears the cycle after a miss is taken; commands and fills hold until accepted.
module cache_miss_unit
    import cache_bus_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 64,
    parameter int CHUNKS_LOG  = 3,
    parameter int CONNECTIONS = 2,
    parameter int CACHE_ID    = 0,
    localparam int LINE_W     = DATA_WIDTH * (2 ** CHUNKS_LOG),
    localparam int ID_W       = (CONNECTIONS > 1) ? $clog2(CONNECTIONS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  victim_dirty,
    input  logic [ADDR_WIDTH-1:0] victim_addr,
    input  logic [LINE_W-1:0]     victim_data,
    output logic                  fill_valid,
    input  logic                  fill_ready,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [LINE_W-1:0]     fill_data,
    output logic                  command_valid,
    output logic                  command_store,
    output logic [ADDR_WIDTH-1:0] command_addr,
    output logic [LINE_W-1:0]     data_in,
    output logic                  command_ready,
    input  logic                  bus_valid,
    input  logic                  bus_ready,
    input  logic [ID_W-1:0]       cacheID,
    input  logic [LINE_W-1:0]     data_out
);

    localparam int OFFSET_BITS = $clog2(DATA_WIDTH / 8) + CHUNKS_LOG;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;
    localparam logic [ID_W-1:0] MY_ID = ID_W'(CACHE_ID);

    miss_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
    logic [LINE_W-1:0]       victim_data_q, victim_data_d;
    logic [LINE_W-1:0]       fill_data_q, fill_data_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    cmd_store_q, cmd_store_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    fill_valid_q, fill_valid_d;
    logic                    wb_skip_q, wb_skip_d;
    logic                    accepted;
    logic                    slot_match;

    assign slot_match = (cacheID == MY_ID);
    assign accepted   = cmd_valid_q & bus_ready & slot_match;

    always_comb begin
        state_d       = state_q;
        miss_addr_d   = miss_addr_q;
        victim_data_d = victim_data_q;
        fill_data_d   = fill_data_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_store_d   = cmd_store_q;
        cmd_ready_d   = 1'b0;
        fill_valid_d  = fill_valid_q;
        wb_skip_d     = wb_skip_q;

        unique case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    miss_addr_d   = miss_addr & ALIGN_MASK;
                    victim_data_d = victim_data;
                    cmd_valid_d   = 1'b1;
                    cmd_store_d   = victim_dirty;
                    cmd_addr_d    = (victim_dirty ? victim_addr : miss_addr) & ALIGN_MASK;
                    state_d       = victim_dirty ? WB_REQ : LD_REQ;
                end
            end
            WB_REQ: begin
                if (accepted) begin
                    cmd_valid_d = 1'b0;
                    wb_skip_d   = 1'b1;
                    state_d     = WB_WAIT;
                end
            end
            WB_WAIT: begin
                // bus_ready is still high from the handshake itself, so skip one cycle
                if (wb_skip_q) begin
                    wb_skip_d = 1'b0;
                end else if (bus_ready) begin
                    cmd_valid_d = 1'b1;
                    cmd_store_d = 1'b0;
                    cmd_addr_d  = miss_addr_q;
                    state_d     = LD_REQ;
                end
            end
            LD_REQ: begin
                if (accepted) begin
                    cmd_valid_d = 1'b0;
                    state_d     = LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (bus_valid && slot_match) begin
                    fill_data_d  = data_out;
                    cmd_ready_d  = 1'b1;
                    fill_valid_d = 1'b1;
                    state_d      = FILL;
                end
            end
            FILL: begin
                if (fill_ready) begin
                    fill_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            miss_addr_q   <= '0;
            victim_data_q <= '0;
            fill_data_q   <= '0;
            cmd_addr_q    <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_store_q   <= 1'b0;
            cmd_ready_q   <= 1'b0;
            fill_valid_q  <= 1'b0;
            wb_skip_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            miss_addr_q   <= miss_addr_d;
            victim_data_q <= victim_data_d;
            fill_data_q   <= fill_data_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_store_q   <= cmd_store_d;
            cmd_ready_q   <= cmd_ready_d;
            fill_valid_q  <= fill_valid_d;
            wb_skip_q     <= wb_skip_d;
        end
    end

    assign miss_ready    = (state_q == IDLE);
    assign fill_valid    = fill_valid_q;
    assign fill_addr     = miss_addr_q;
    assign fill_data     = fill_data_q;
    assign command_valid = cmd_valid_q;
    assign command_store = cmd_store_q;
    assign command_addr  = cmd_addr_q;
    assign data_in       = victim_data_q;
    assign command_ready = cmd_ready_q;

endmodule
